// File: rtl/alu_pkg.sv
// Shared arithmetic definitions for the add/sub datapath.
//   OP_ADD / OP_SUB : encoding of the 1-bit operation select
//   MAX_W           : widest operand the helper functions support
//   CNT_W           : width of the overflow event counter
//   smax(w)/smin(w) : two's-complement extremes of a w-bit signed value,
//                     returned as MAX_W-bit patterns (use the low w bits)
package alu_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int MAX_W = 64;
  localparam int CNT_W = 16;

  function automatic logic [MAX_W-1:0] smax(input int unsigned w);
    return (MAX_W'(1) << (w - 1)) - MAX_W'(1);
  endfunction

  // Only the sign bit set: the most negative w-bit value.
  function automatic logic [MAX_W-1:0] smin(input int unsigned w);
    return MAX_W'(1) << (w - 1);
  endfunction

endpackage

// File: rtl/iaxistream.sv
// Minimal AXI4-Stream bundle used across the codebase.
//   tdata  : payload, DATA_W bits
//   tvalid : source has a beat
//   tready : sink accepts the beat
//   tlast  : packet boundary marker
//   tid    : stream identifier, ID_W bits
// Modports: Master drives payload/valid, Slave drives ready.
interface IAxiStream #(
  parameter int DATA_W = 32,
  parameter int ID_W   = 1
);
  logic [DATA_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;
  logic [ID_W-1:0]   tid;

  modport Master (output tdata, tvalid, tlast, tid, input tready);
  modport Slave  (input tdata, tvalid, tlast, tid, output tready);
endinterface

// File: rtl/addsub_core.sv
// Width-parametric signed add/subtract with overflow detection and optional
// saturation. Purely combinational.
//   a, b : signed operands, DATA_W bits
//   op   : OP_ADD -> a + b, OP_SUB -> a - b
//   y    : result (clamped when SATURATE != 0, wrapped otherwise)
//   ovf  : the exact DATA_W+1-bit result does not fit in DATA_W bits
module addsub_core
  import alu_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int SATURATE = 1
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              op,
  output logic [DATA_W-1:0] y,
  output logic              ovf
);

  localparam logic [DATA_W-1:0] MAX_V = DATA_W'(smax(DATA_W));
  localparam logic [DATA_W-1:0] MIN_V = DATA_W'(smin(DATA_W));

  logic [DATA_W:0] a_x;
  logic [DATA_W:0] b_x;
  logic [DATA_W:0] sum;

  // NOTE: every output of this block gets a value on every path (y has a
  // default before the conditional clamp), so no latch is inferred.
  always_comb begin
    a_x = {a[DATA_W-1], a};
    b_x = {b[DATA_W-1], b};
    sum = (op == OP_SUB) ? (a_x - b_x) : (a_x + b_x);
    // One extra bit holds any sum of two DATA_W values; the result fits only
    // when the top two bits agree.
    ovf = sum[DATA_W] ^ sum[DATA_W-1];
    y   = sum[DATA_W-1:0];
    if ((SATURATE != 0) && ovf) begin
      y = sum[DATA_W] ? MIN_V : MAX_V;
    end
  end

endmodule

// File: rtl/axis_addsub_pipe.sv
// Streaming signed adder/subtractor with a LATENCY-deep pipeline.
// A pair is consumed only when both input streams are valid and the pipeline
// can advance; results come out in order with backpressure on result.
//   aclk     : clock, rising edge
//   aresetn  : synchronous active-low reset (valid bits and counter only)
//   a, b     : operand streams (slave), tlast of the pair is OR-ed
//   op       : OP_ADD / OP_SUB for the pair accepted this cycle
//   result   : result stream (master), tid tied to 0
//   ovf_flag : presented result beat overflowed
//   ovf_cnt  : saturating count of overflowed beats transferred on result
//   ovf_clr  : synchronous clear of ovf_cnt, wins over an increment
module axis_addsub_pipe
  import alu_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int LATENCY  = 2,
  parameter int SATURATE = 1
) (
  input  logic             aclk,
  input  logic             aresetn,
  IAxiStream.Slave         a,
  IAxiStream.Slave         b,
  input  logic             op,
  IAxiStream.Master        result,
  output logic             ovf_flag,
  output logic [CNT_W-1:0] ovf_cnt,
  input  logic             ovf_clr
);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              last;
    logic              ovf;
  } beat_t;

  logic [LATENCY-1:0] stg_vld;
  beat_t              stg [LATENCY];

  logic              out_valid;
  logic              en;
  logic              fire;
  logic [DATA_W-1:0] core_y;
  logic              core_ovf;

  // The whole pipe moves in lockstep: it may advance whenever the output
  // register is empty or being drained this cycle.
  assign out_valid = stg_vld[LATENCY-1];
  assign en        = !out_valid || result.tready;
  // Both readies come from the same term, so a beat is never taken from one
  // stream alone. Gated by reset so nothing is consumed while held in reset.
  assign fire      = aresetn && en && a.tvalid && b.tvalid;
  assign a.tready  = fire;
  assign b.tready  = fire;

  addsub_core #(
    .DATA_W   (DATA_W),
    .SATURATE (SATURATE)
  ) u_core (
    .a   (a.tdata),
    .b   (b.tdata),
    .op  (op),
    .y   (core_y),
    .ovf (core_ovf)
  );

  // NOTE: sequential state uses non-blocking assignments so every stage
  // samples its predecessor's pre-edge value regardless of statement order.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      stg_vld <= '0;
    end else if (en) begin
      // A cycle without a fire loads a bubble, so nothing is emitted twice.
      stg_vld[0] <= fire;
      for (int i = 1; i < LATENCY; i++) begin
        stg_vld[i] <= stg_vld[i-1];
      end
    end
  end

  // NOTE: the payload registers carry no reset; a stage's contents are only
  // observed when its valid bit is set, and the valid bits are reset.
  always_ff @(posedge aclk) begin
    if (en) begin
      stg[0] <= '{data: core_y, last: a.tlast | b.tlast, ovf: core_ovf};
      for (int i = 1; i < LATENCY; i++) begin
        stg[i] <= stg[i-1];
      end
    end
  end

  assign result.tvalid = out_valid;
  assign result.tdata  = stg[LATENCY-1].data;
  assign result.tlast  = stg[LATENCY-1].last;
  assign result.tid    = '0;
  assign ovf_flag      = out_valid && stg[LATENCY-1].ovf;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      ovf_cnt <= '0;
    end else if (ovf_clr) begin
      ovf_cnt <= '0;
    end else if (ovf_flag && result.tready && (ovf_cnt != '1)) begin
      ovf_cnt <= ovf_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_axis_addsub_pipe.sv
// Self-checking bench for axis_addsub_pipe (DATA_W=16, LATENCY=2).
// A saturating and a wrapping instance see identical stimulus and run in
// lockstep; a scoreboard queue holds the expected beat for each accepted pair.
module tb_axis_addsub_pipe;

  localparam int DW  = 16;
  localparam int LAT = 2;

  typedef struct {
    logic [DW-1:0] sat;
    logic [DW-1:0] wrap;
    logic          ovf;
    logic          last;
    int            cyc;
  } exp_t;

  logic          aclk    = 1'b0;
  logic          aresetn = 1'b0;
  logic          op      = 1'b0;
  logic          ovf_clr = 1'b0;
  logic          ovf_flag, ovf_flag_w;
  logic [15:0]   ovf_cnt, ovf_cnt_w;
  logic          rdy      = 1'b1;
  logic          tog_mode = 1'b0;
  logic          tog      = 1'b0;

  IAxiStream #(.DATA_W(DW)) a_if ();
  IAxiStream #(.DATA_W(DW)) b_if ();
  IAxiStream #(.DATA_W(DW)) r_if ();
  IAxiStream #(.DATA_W(DW)) a2_if ();
  IAxiStream #(.DATA_W(DW)) b2_if ();
  IAxiStream #(.DATA_W(DW)) r2_if ();

  assign r_if.tready  = tog_mode ? tog : rdy;
  assign r2_if.tready = r_if.tready;
  assign a2_if.tdata  = a_if.tdata;
  assign a2_if.tvalid = a_if.tvalid;
  assign a2_if.tlast  = a_if.tlast;
  assign a2_if.tid    = a_if.tid;
  assign b2_if.tdata  = b_if.tdata;
  assign b2_if.tvalid = b_if.tvalid;
  assign b2_if.tlast  = b_if.tlast;
  assign b2_if.tid    = b_if.tid;

  axis_addsub_pipe #(.DATA_W(DW), .LATENCY(LAT), .SATURATE(1)) dut (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .a        (a_if),
    .b        (b_if),
    .op       (op),
    .result   (r_if),
    .ovf_flag (ovf_flag),
    .ovf_cnt  (ovf_cnt),
    .ovf_clr  (ovf_clr)
  );

  axis_addsub_pipe #(.DATA_W(DW), .LATENCY(LAT), .SATURATE(0)) dut_wrap (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .a        (a2_if),
    .b        (b2_if),
    .op       (op),
    .result   (r2_if),
    .ovf_flag (ovf_flag_w),
    .ovf_cnt  (ovf_cnt_w),
    .ovf_clr  (ovf_clr)
  );

  always #5 aclk = ~aclk;

  always @(negedge aclk) tog <= ~tog;

  int            n_tests   = 0;
  int            n_fail    = 0;
  int            fire_cnt  = 0;
  int            out_cnt   = 0;
  int            tlast_cnt = 0;
  int            cyc       = 0;
  int            last_lat  = 0;
  logic [15:0]   model_cnt = '0;
  logic [DW-1:0] last_data = '0;
  logic [DW-1:0] last_wrap = '0;
  logic          last_ovf  = 1'b0;
  logic          last_last = 1'b0;
  logic          lat_chk   = 1'b0;
  logic          hold_vld  = 1'b0;
  logic [DW-1:0] hold_data = '0;
  logic          hold_last = 1'b0;
  logic          hold_ovf  = 1'b0;
  logic          prev_rst  = 1'b1;
  exp_t          q[$];
  exp_t          mon_e;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [DW-1:0] av, input logic [DW-1:0] bv,
                                 input logic o, input logic l, input int c);
    exp_t        e;
    longint      sa;
    longint      sb;
    longint      s;
    logic [63:0] su;
    sa = longint'($signed(av));
    sb = longint'($signed(bv));
    s  = o ? (sa - sb) : (sa + sb);
    su = s;
    e.wrap = su[DW-1:0];
    e.ovf  = (s > 32767) || (s < -32768);
    e.sat  = (s > 32767) ? 16'h7FFF : ((s < -32768) ? 16'h8000 : su[DW-1:0]);
    e.last = l;
    e.cyc  = c;
    return e;
  endfunction

  // Monitor: runs 1 ns before each rising edge, when inputs and outputs are
  // stable, and evaluates the handshakes that edge will complete.
  always begin
    @(negedge aclk);
    #4;
    cyc++;
    if (!aresetn) begin
      check("rst_a_tready", a_if.tready, 0);
      check("rst_b_tready", b_if.tready, 0);
      q.delete();
      model_cnt = '0;
      hold_vld  = 1'b0;
      prev_rst  = 1'b1;
    end else begin
      if (prev_rst) begin
        check("post_rst_tvalid", r_if.tvalid, 0);
        check("post_rst_ovf_flag", ovf_flag, 0);
      end
      prev_rst = 1'b0;
      check("ovf_cnt", ovf_cnt, model_cnt);
      check("ovf_cnt_wrap", ovf_cnt_w, model_cnt);
      if (hold_vld) begin
        check("hold_tvalid", r_if.tvalid, 1);
        check("hold_tdata", r_if.tdata, hold_data);
        check("hold_tlast", r_if.tlast, hold_last);
        check("hold_ovf_flag", ovf_flag, hold_ovf);
      end
      hold_vld  = r_if.tvalid && !r_if.tready;
      hold_data = r_if.tdata;
      hold_last = r_if.tlast;
      hold_ovf  = ovf_flag;
      if (a_if.tvalid && b_if.tvalid) begin
        check("pair_tready", a_if.tready, b_if.tready);
      end else begin
        check("lone_tready", {a_if.tready, b_if.tready}, 0);
      end
      if (a_if.tready && b_if.tready) begin
        q.push_back(model(a_if.tdata, b_if.tdata, op, a_if.tlast | b_if.tlast, cyc));
        fire_cnt++;
      end
      if (r_if.tvalid && r_if.tready) begin
        if (q.size() == 0) begin
          check("spurious_beat", r_if.tdata, 64'hDEAD_0000);
        end else begin
          mon_e = q.pop_front();
          check("tdata_sat", r_if.tdata, mon_e.sat);
          check("tdata_wrap", r2_if.tdata, mon_e.wrap);
          check("wrap_tvalid", r2_if.tvalid, 1);
          check("ovf_flag", ovf_flag, mon_e.ovf);
          check("ovf_flag_wrap", ovf_flag_w, mon_e.ovf);
          check("tlast", r_if.tlast, mon_e.last);
          check("tid", r_if.tid, 0);
          if (lat_chk) check("latency", cyc - mon_e.cyc, LAT);
          last_data = r_if.tdata;
          last_wrap = r2_if.tdata;
          last_ovf  = ovf_flag;
          last_last = r_if.tlast;
          last_lat  = cyc - mon_e.cyc;
          out_cnt++;
          if (r_if.tlast) tlast_cnt++;
          if (ovf_clr) model_cnt = '0;
          else if (mon_e.ovf && model_cnt != 16'hFFFF) model_cnt = model_cnt + 1'b1;
        end
      end else if (ovf_clr) begin
        model_cnt = '0;
      end
    end
  end

  // Caller is just past a falling edge; returns on the falling edge after the
  // pair was accepted, leaving the valids asserted for back-to-back use.
  task automatic drive_pair(input logic [DW-1:0] av, input logic [DW-1:0] bv,
                            input logic o, input logic al, input logic bl);
    int start;
    a_if.tdata  = av;
    b_if.tdata  = bv;
    a_if.tlast  = al;
    b_if.tlast  = bl;
    a_if.tvalid = 1'b1;
    b_if.tvalid = 1'b1;
    op          = o;
    start       = fire_cnt;
    for (int i = 0; i < 100 && fire_cnt == start; i++) @(negedge aclk);
    check("fire", fire_cnt - start, 1);
  endtask

  task automatic idle();
    a_if.tvalid = 1'b0;
    b_if.tvalid = 1'b0;
    a_if.tlast  = 1'b0;
    b_if.tlast  = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge aclk);
    check("drain", q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int start;
    int tl_start;
    int c0;
    a_if.tdata = '0; a_if.tvalid = 1'b0; a_if.tlast = 1'b0; a_if.tid = '0;
    b_if.tdata = '0; b_if.tvalid = 1'b0; b_if.tlast = 1'b0; b_if.tid = '0;
    repeat (3) @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    check("reset_cnt", ovf_cnt, 0);
    check("reset_tvalid", r_if.tvalid, 0);

    // 5 - 3, ready high throughout
    lat_chk = 1'b1;
    drive_pair(16'h0005, 16'h0003, 1'b1, 1'b0, 1'b0);
    idle();
    drain();
    check("sub_result", last_data, 16'h0002);
    check("sub_ovf", last_ovf, 0);
    check("sub_latency", last_lat, 2);

    // positive overflow
    drive_pair(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    idle();
    drain();
    check("pos_sat", last_data, 16'h7FFF);
    check("pos_wrap", last_wrap, 16'h8000);
    check("pos_ovf", last_ovf, 1);
    check("pos_cnt", ovf_cnt, 1);

    // negative overflow via subtract
    drive_pair(16'h8000, 16'h0001, 1'b1, 1'b0, 1'b0);
    idle();
    drain();
    check("neg_sat", last_data, 16'h8000);
    check("neg_wrap", last_wrap, 16'h7FFF);
    check("neg_ovf", last_ovf, 1);

    // back-to-back stream: one accept per cycle
    c0 = cyc;
    for (int i = 0; i < 8; i++) begin
      drive_pair(16'($urandom), 16'($urandom), 1'($urandom), 1'b0, 1'b0);
    end
    check("stream_rate", cyc - c0, 8);
    idle();
    drain();
    lat_chk = 1'b0;

    // a valid alone for 4 cycles, then b joins
    start = out_cnt;
    a_if.tdata  = 16'h1234;
    a_if.tvalid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge aclk);
      #1;
      check("lone_a_tready", a_if.tready, 0);
      check("lone_b_tready", b_if.tready, 0);
      check("lone_no_out", r_if.tvalid, 0);
    end
    drive_pair(16'h1234, 16'h0100, 1'b0, 1'b0, 1'b0);
    idle();
    drain();
    repeat (3) @(negedge aclk);
    check("lone_one_result", out_cnt - start, 1);
    check("lone_result", last_data, 16'h1334);

    // 10-beat burst under 1010 backpressure, tlast on beat 10
    start    = out_cnt;
    tl_start = tlast_cnt;
    tog_mode = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive_pair(16'($urandom), 16'($urandom), 1'(i % 2), i == 9, 1'b0);
    end
    idle();
    drain();
    tog_mode = 1'b0;
    check("burst_count", out_cnt - start, 10);
    check("burst_tlast_count", tlast_cnt - tl_start, 1);
    check("burst_tlast_last", last_last, 1);

    // reset with two overflowing beats in flight
    rdy   = 1'b0;
    start = out_cnt;
    drive_pair(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0);
    drive_pair(16'h8000, 16'h0001, 1'b1, 1'b0, 1'b0);
    idle();
    aresetn = 1'b0;
    @(negedge aclk);
    aresetn = 1'b1;
    rdy     = 1'b1;
    repeat (8) @(negedge aclk);
    check("rst_no_out", out_cnt - start, 0);
    check("rst_cnt", ovf_cnt, 0);

    // clear coincident with an overflowed transfer
    drive_pair(16'h7FFF, 16'h7FFF, 1'b0, 1'b0, 1'b0);
    idle();
    drain();
    check("pre_clr_cnt", ovf_cnt, 1);
    rdy = 1'b0;
    drive_pair(16'h8000, 16'h8000, 1'b0, 1'b0, 1'b0);
    idle();
    for (int i = 0; i < 20 && !r_if.tvalid; i++) @(negedge aclk);
    check("clr_beat_ready", r_if.tvalid && ovf_flag, 1);
    ovf_clr = 1'b1;
    rdy     = 1'b1;
    @(negedge aclk);
    ovf_clr = 1'b0;
    #1;
    check("clr_cnt", ovf_cnt, 0);
    check("clr_wrap_val", last_wrap, 16'h0000);
    drain();

    repeat (3) @(negedge aclk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/axis_addsub_pipe.md
AXIS_ADDSUB_PIPE -- requirements
Module: axis_addsub_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand/result width in bits, legal 8..64.
REQ-002 SHALL have parameter LATENCY, default 2, accept-to-result pipeline depth in cycles, legal 1..4.
REQ-003 SHALL have parameter SATURATE, default 1, 1 = clamp on overflow, 0 = two's-complement wrap.
REQ-004 SHALL have port aclk  input  1  clock, all logic rising-edge.
REQ-005 SHALL have port aresetn  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port a  IAxiStream.Slave  DATA_W  minuend/augend stream, uses tdata, tvalid, tready, tlast.
REQ-007 SHALL have port b  IAxiStream.Slave  DATA_W  subtrahend/addend stream, uses tdata, tvalid, tready, tlast.
REQ-008 SHALL have port op  input  1  operation for the pair accepted this cycle, 0 = add, 1 = subtract.
REQ-009 SHALL have port result  IAxiStream.Master  DATA_W  result stream, drives tdata, tvalid, tlast, tid, honours tready.
REQ-010 SHALL have port ovf_flag  output  1  high with result.tvalid when the presented beat overflowed.
REQ-011 SHALL have port ovf_cnt  output  16  count of overflowed beats transferred on result.
REQ-012 SHALL have port ovf_clr  input  1  synchronous clear of ovf_cnt.

Function
REQ-013 SHALL define pipeline enable en = !out_valid || result.tready; all stages advance together only when en = 1.
REQ-014 SHALL drive a.tready = b.tready = en && a.tvalid && b.tvalid, so a beat is never consumed from one stream without the other.
REQ-015 SHALL accept a pair (fire) when a.tvalid && b.tvalid && en; a lone valid on either stream is held, not consumed.
REQ-016 SHALL present the result of a fire on result exactly LATENCY cycles later when result.tready stays high.
REQ-017 SHALL sustain one result per cycle under continuous valid and ready.
REQ-018 SHALL hold result.tdata, tlast, ovf_flag and tvalid stable while result.tvalid && !result.tready.
REQ-019 SHALL compute signed a.tdata + b.tdata (op=0) or a.tdata - b.tdata (op=1) at DATA_W+1 bits.
REQ-020 SHALL flag overflow when the DATA_W+1-bit sum lies outside [-2^(DATA_W-1), 2^(DATA_W-1)-1].
REQ-021 SHALL output 2^(DATA_W-1)-1 on positive overflow and -2^(DATA_W-1) on negative overflow when SATURATE=1.
REQ-022 SHALL output the low DATA_W bits of the sum when SATURATE=0; ovf_flag is still asserted.
REQ-023 SHALL drive result.tlast = a.tlast | b.tlast of the originating pair, delayed with its data.
REQ-024 SHALL drive result.tid = 0 constantly.
REQ-025 SHALL increment ovf_cnt on each result transfer (tvalid && tready) with ovf_flag = 1, saturating at 16'hFFFF.
REQ-026 SHALL give ovf_clr priority over a simultaneous increment; ovf_cnt becomes 0 that cycle.
REQ-027 SHALL let bubbles (cycles without a fire while en = 1) propagate as invalid stages, never emitting a duplicate beat.

Reset
REQ-028 SHALL, while aresetn = 0, clear all stage-valid bits; result.tvalid = 0, ovf_flag = 0, ovf_cnt = 0, a.tready = b.tready = 0.
REQ-029 SHALL discard in-flight beats on reset mid-operation and emit no result for them after release.
REQ-030 SHALL leave datapath registers unreset; only valid bits and counters are reset.

Structure
REQ-031 SHALL place op encoding constants (OP_ADD = 0, OP_SUB = 1) and signed max/min functions of width in shared package alu_pkg.
REQ-032 SHALL factor the width-parametric combinational add/sub plus overflow/saturation into sub-module addsub_core (inputs a, b, op; outputs y, ovf).
REQ-033 SHALL implement the LATENCY stages as a generate-sized register array of {valid, data, last, ovf}.

Verification (DATA_W=16, LATENCY=2, SATURATE=1 unless stated)
REQ-034 SHALL cover a=0x0005, b=0x0003, op=1, ready high -> result 0x0002, ovf_flag 0, 2 cycles after fire.
REQ-035 SHALL cover a=0x7FFF, b=0x0001, op=0 -> 0x7FFF, ovf_flag 1, ovf_cnt 1; SATURATE=0 -> 0x8000, ovf_flag 1.
REQ-036 SHALL cover a=0x8000, b=0x0001, op=1 -> 0x8000 saturated, ovf_flag 1.
REQ-037 SHALL cover a valid 4 cycles before b valid -> no tready, no output until both valid, then exactly one result.
REQ-038 SHALL cover a 10-beat burst with result.tready toggling 1010... -> 10 in-order results, no loss or duplicate, tlast only on beat 10 when a.tlast marks beat 10.
REQ-039 SHALL cover aresetn low for 1 cycle with 2 beats in flight -> no result emitted after release; ovf_cnt = 0; ovf_clr coincident with an overflow transfer -> ovf_cnt = 0.
